// File: rtl/apb_periph_demux_n.sv
// apb_periph_demux_n: single-outstanding N-way peripheral-bus demux.
// Master side: data_req_i/data_add_i/data_wen_i/data_wdata_i/data_be_i/data_ID_i
//   in; data_gnt_o and data_r_valid_o/data_r_rdata_o/data_r_ID_o/data_r_opc_o out.
// Target side: slv_req_o one-hot, broadcast slv_add/wen/wdata/be; slv_gnt_i,
//   slv_r_valid_i and slv_r_rdata_i (slice i = target i) in.
// clk, rst_i: synchronous active-high reset.
// Optional macro APB_PERIPH_DEMUX_TIMEOUT_EN: error response for hung targets.
module apb_periph_demux_n #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int ID_WIDTH       = 10,
  parameter int NUM_SLAVES     = 4,
  parameter int DEC_LSB        = 20,
  parameter int DEC_WIDTH      = 2,
  parameter logic [NUM_SLAVES-1:0] SLAVE_MASK = 4'b1110,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = 32'hBADACCE5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic                           data_req_i,
  input  logic [ADDR_WIDTH-1:0]          data_add_i,
  input  logic                           data_wen_i,
  input  logic [DATA_WIDTH-1:0]          data_wdata_i,
  input  logic [BE_WIDTH-1:0]            data_be_i,
  input  logic [ID_WIDTH-1:0]            data_ID_i,
  output logic                           data_gnt_o,
  output logic                           data_r_valid_o,
  output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
  output logic [ID_WIDTH-1:0]            data_r_ID_o,
  output logic                           data_r_opc_o,
  output logic [NUM_SLAVES-1:0]          slv_req_o,
  output logic [ADDR_WIDTH-1:0]          slv_add_o,
  output logic                           slv_wen_o,
  output logic [DATA_WIDTH-1:0]          slv_wdata_o,
  output logic [BE_WIDTH-1:0]            slv_be_o,
  input  logic [NUM_SLAVES-1:0]          slv_gnt_i,
  input  logic [NUM_SLAVES-1:0]          slv_r_valid_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_r_rdata_i
);

  localparam int SEL_W = (NUM_SLAVES > 1) ?
                         $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    ERR_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;

  logic [DEC_WIDTH-1:0]  idx;
  logic [NUM_SLAVES-1:0] hit_oh;
  logic [SEL_W-1:0]      idx_sel;
  logic                  mapped;
  logic                  sel_valid;

`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ?
                         $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign slv_add_o   = data_add_i;
  assign slv_wen_o   = data_wen_i;
  assign slv_wdata_o = data_wdata_i;
  assign slv_be_o    = data_be_i;
  assign data_r_ID_o = id_q;

  assign idx = data_add_i[DEC_LSB +: DEC_WIDTH];

  // Compare at full integer width so decode values beyond
  // NUM_SLAVES can never alias onto a real port.
  always_comb begin
    hit_oh  = '0;
    idx_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx) == i) begin
        hit_oh[i] = 1'b1;
        idx_sel   = SEL_W'(i);
      end
    end
  end

  assign mapped    = |(hit_oh & SLAVE_MASK);
  assign sel_valid = slv_r_valid_i[sel_q];

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    id_d           = id_q;
    slv_req_o      = '0;
    data_gnt_o     = 1'b0;
    data_r_valid_o = 1'b0;
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    // Outputs are forced quiet while reset is held.
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (data_req_i) begin
            if (mapped) begin
              slv_req_o  = hit_oh;
              data_gnt_o = |(hit_oh & slv_gnt_i);
              if (data_gnt_o) begin
                sel_d   = idx_sel;
                id_d    = data_ID_i;
                state_d = WAIT_RESP;
`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
                cnt_d   = '0;
`endif
              end
            end else begin
              data_gnt_o = 1'b1;
              id_d       = data_ID_i;
              state_d    = ERR_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (sel_valid) begin
            data_r_valid_o = 1'b1;
            data_r_rdata_o =
              slv_r_rdata_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
            state_d        = IDLE;
          end
`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
          else if (cnt_q == CNT_MAX) begin
            data_r_valid_o = 1'b1;
            data_r_rdata_o = ERR_RDATA;
            data_r_opc_o   = 1'b1;
            state_d        = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        ERR_RESP: begin
          data_r_valid_o = 1'b1;
          data_r_rdata_o = ERR_RDATA;
          data_r_opc_o   = 1'b1;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      id_q    <= '0;
`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_periph_demux_n.sv
// tb_apb_periph_demux_n: directed + randomized bench for apb_periph_demux_n.
// Expected values come from a transaction-level model of the decode rules.
module tb_apb_periph_demux_n;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int IW = 10;
  localparam int NS = 4;
  localparam int TC = 8;
  localparam logic [DW-1:0] ERRD = 32'hBADACCE5;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              data_req_i;
  logic [AW-1:0]     data_add_i;
  logic              data_wen_i;
  logic [DW-1:0]     data_wdata_i;
  logic [BW-1:0]     data_be_i;
  logic [IW-1:0]     data_ID_i;
  logic              data_gnt_o;
  logic              data_r_valid_o;
  logic [DW-1:0]     data_r_rdata_o;
  logic [IW-1:0]     data_r_ID_o;
  logic              data_r_opc_o;
  logic [NS-1:0]     slv_req_o;
  logic [AW-1:0]     slv_add_o;
  logic              slv_wen_o;
  logic [DW-1:0]     slv_wdata_o;
  logic [BW-1:0]     slv_be_o;
  logic [NS-1:0]     slv_gnt_i;
  logic [NS-1:0]     slv_r_valid_i;
  logic [NS*DW-1:0]  slv_r_rdata_i;

  int checks = 0;
  int failures = 0;
  logic [NS-1:0] mask = 4'b1110;

  apb_periph_demux_n #(
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_add_i(data_add_i),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i),
    .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o), .data_r_ID_o(data_r_ID_o),
    .data_r_opc_o(data_r_opc_o), .slv_req_o(slv_req_o),
    .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
    .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o),
    .slv_gnt_i(slv_gnt_i), .slv_r_valid_i(slv_r_valid_i),
    .slv_r_rdata_i(slv_r_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_in();
    data_req_i    = 1'b0;
    slv_gnt_i     = '0;
    slv_r_valid_i = '0;
    slv_r_rdata_i = '0;
  endtask

  function automatic logic [NS-1:0] oh(input int i);
    return NS'(1) << i;
  endfunction

  task automatic rnd_rdata();
    for (int s = 0; s < NS; s++)
      slv_r_rdata_i[s*DW +: DW] = $urandom;
  endtask

  task automatic quiet_chk(input string tag);
    chk({tag, "_val"}, data_r_valid_o, 0);
    chk({tag, "_rd"}, data_r_rdata_o, 0);
    chk({tag, "_opc"}, data_r_opc_o, 0);
  endtask

  // One full transaction: request/grant phase, wait phase,
  // response cycle (with a fresh request that must not be granted).
  task automatic txn(input logic [AW-1:0] a,
                     input logic [IW-1:0] id,
                     input int gd, input int rd,
                     input bit stray,
                     input logic [DW-1:0] rsp);
    int idx;
    bit m;
    idx = int'(a[21:20]);
    m = mask[idx];
    data_req_i   = 1'b1;
    data_add_i   = a;
    data_wen_i   = 1'($urandom);
    data_wdata_i = $urandom;
    data_be_i    = BW'($urandom);
    data_ID_i    = id;
    if (!m) begin
      slv_gnt_i = NS'($urandom);
      slv_r_valid_i = stray ? NS'($urandom) : '0;
      settle();
      chk("u_req", slv_req_o, 0);
      chk("u_gnt", data_gnt_o, 1);
      chk("u_val0", data_r_valid_o, 0);
      chk("bc_add", slv_add_o, a);
      chk("bc_wd", slv_wdata_o, data_wdata_i);
      tick();
      data_ID_i = IW'($urandom);
      slv_gnt_i = '1;
      settle();
      chk("e_val", data_r_valid_o, 1);
      chk("e_rd", data_r_rdata_o, ERRD);
      chk("e_opc", data_r_opc_o, 1);
      chk("e_id", data_r_ID_o, id);
      chk("e_gnt", data_gnt_o, 0);
      tick();
    end else begin
      for (int k = 0; k <= gd; k++) begin
        slv_gnt_i = (k == gd) ? oh(idx) : '0;
        slv_gnt_i |= NS'($urandom) & ~oh(idx);
        slv_r_valid_i = stray ? NS'($urandom) : '0;
        rnd_rdata();
        settle();
        chk("m_req", slv_req_o, oh(idx));
        chk("m_gnt", data_gnt_o, (k == gd));
        quiet_chk("m_idle");
        tick();
      end
      data_ID_i = IW'($urandom);
      for (int k = 0; k < rd; k++) begin
        data_req_i = 1'($urandom);
        data_add_i = $urandom;
        slv_gnt_i = NS'($urandom);
        slv_r_valid_i = stray ?
          (NS'($urandom) & ~oh(idx)) : '0;
        rnd_rdata();
        settle();
        chk("w_gnt", data_gnt_o, 0);
        chk("w_req", slv_req_o, 0);
        quiet_chk("w");
        tick();
      end
      data_req_i = 1'b1;
      slv_gnt_i = '1;
      slv_r_valid_i = oh(idx);
      if (stray) slv_r_valid_i |= NS'($urandom);
      rnd_rdata();
      slv_r_rdata_i[idx*DW +: DW] = rsp;
      settle();
      chk("r_val", data_r_valid_o, 1);
      chk("r_rd", data_r_rdata_o, rsp);
      chk("r_id", data_r_ID_o, id);
      chk("r_opc", data_r_opc_o, 0);
      chk("r_gnt", data_gnt_o, 0);
      chk("r_req", slv_req_o, 0);
      tick();
    end
    idle_in();
  endtask

`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
  task automatic tmo_silent(input logic [AW-1:0] a,
                            input logic [IW-1:0] id);
    data_req_i = 1'b1;
    data_add_i = a;
    data_ID_i  = id;
    slv_gnt_i  = oh(int'(a[21:20]));
    settle();
    chk("t_gnt", data_gnt_o, 1);
    tick();
    idle_in();
    for (int k = 1; k < TC; k++) begin
      settle();
      quiet_chk("t_wait");
      tick();
    end
    settle();
    chk("t_val", data_r_valid_o, 1);
    chk("t_rd", data_r_rdata_o, ERRD);
    chk("t_opc", data_r_opc_o, 1);
    chk("t_id", data_r_ID_o, id);
    tick();
  endtask
`endif

  initial begin
    logic [AW-1:0] a;
    rst_i = 1'b1;
    idle_in();
    data_add_i = '0;
    data_wen_i = 1'b0;
    data_wdata_i = '0;
    data_be_i = '0;
    data_ID_i = '0;
    tick();
    // Reset holds outputs quiet even with live inputs.
    data_req_i = 1'b1;
    data_add_i = 32'h1A30_0000;
    slv_gnt_i = '1;
    slv_r_valid_i = '1;
    rnd_rdata();
    settle();
    chk("rst_gnt", data_gnt_o, 0);
    chk("rst_req", slv_req_o, 0);
    quiet_chk("rst");
    tick();
    rst_i = 1'b0;
    idle_in();
    settle();
    chk("rst_id", data_r_ID_o, 0);
    quiet_chk("post_rst");
    // IDLE ignores slave responses.
    slv_r_valid_i = '1;
    rnd_rdata();
    settle();
    quiet_chk("idle_stray");
    tick();
    idle_in();

    txn(32'h1A30_0010, 10'h055, 0, 1, 0, 32'hCAFE_0001);
    txn(32'h1A00_0000, 10'h123, 0, 0, 0, 32'h0);
    txn(32'h1A10_0000, 10'h0A1, 3, 0, 1, 32'h0BAD_F00D);
    txn(32'h1A20_0000, 10'h2F2, 0, 3, 1, 32'h2222_2222);

    // Reset in WAIT_RESP aborts; late response is dropped.
    data_req_i = 1'b1;
    data_add_i = 32'h1A20_0040;
    data_ID_i = 10'h3C3;
    slv_gnt_i = oh(2);
    settle();
    chk("ra_gnt", data_gnt_o, 1);
    tick();
    idle_in();
    rst_i = 1'b1;
    data_req_i = 1'b1;
    slv_gnt_i = '1;
    settle();
    chk("ra_gnt0", data_gnt_o, 0);
    chk("ra_req0", slv_req_o, 0);
    quiet_chk("ra_in");
    tick();
    rst_i = 1'b0;
    idle_in();
    slv_r_valid_i = oh(2);
    slv_r_rdata_i[2*DW +: DW] = 32'h5555_AAAA;
    settle();
    quiet_chk("ra_late");
    chk("ra_id", data_r_ID_o, 0);
    tick();
    idle_in();

`ifdef APB_PERIPH_DEMUX_TIMEOUT_EN
    tmo_silent(32'h1A10_0000, 10'h111);
    idle_in();
    txn(32'h1A30_0000, 10'h222, 0, TC - 1, 0, 32'h7777_0008);
`endif

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      txn(a, IW'($urandom),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 6)),
          1'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
